hmem_arbn: RTL
==============

HMEM_ARBN -- requirements
Module: hmem_arbn

Interface
REQ-001 Parameter N_CH, default 4: number of requester channels, legal range 2..8.
REQ-002 Parameter LINE, default `HMEM_LINE: line width in bits for every channel and for the upstream port.
REQ-003 Parameter AW, default 64: address width.
REQ-004 Port clk  in  1: single clock, all state on rising edge.
REQ-005 Port rst_n  in  1: reset, asynchronous assert, active-low.
REQ-006 Port b_addr  in  N_CH*AW: per-channel line address, channel k at bits [k*AW +: AW].
REQ-007 Port b_rd  in  N_CH: per-channel read request, level.
REQ-008 Port b_wr  in  N_CH: per-channel write request, level.
REQ-009 Port b_data_out  in  N_CH*LINE: per-channel write data, channel k at [k*LINE +: LINE].
REQ-010 Port b_data_in  out  LINE: shared read-return data, valid while b_dv is nonzero.
REQ-011 Port b_dv  out  N_CH: one-hot completion pulse for the granted channel.
REQ-012 Port h_addr  out  AW: upstream address.
REQ-013 Port h_rd, h_wr  out  1 each: upstream read/write strobes, level, held until h_dv.
REQ-014 Port h_data_out  out  LINE: upstream write data.
REQ-015 Port h_data_in  in  LINE: upstream read data, valid with h_dv.
REQ-016 Port h_dv  in  1: upstream completion, one cycle.
REQ-017 Port inv  out  1: invalidate pulse.
REQ-018 Port inv_addr  out  AW: address to invalidate.
REQ-019 Port inv_mask  out  N_CH: channels that must invalidate.

Function
REQ-020 FSM states: IDLE, BUSY, DONE.
REQ-021 IDLE: a channel is requesting when b_rd[k] or b_wr[k] is set; if any, grant via round-robin starting at (last_gnt+1) mod N_CH; latch grant id, address, data, op; go to BUSY next cycle.
REQ-022 If b_rd[k] and b_wr[k] are both set, the channel is treated as a write.
REQ-023 BUSY: h_addr and h_data_out are driven from latched values; h_rd or h_wr is held at 1 according to the latched op; latency from grant to the first strobe is 1 cycle.
REQ-024 BUSY with h_dv=1: capture h_data_in into b_data_in; drop h_rd/h_wr on the next cycle; go to DONE.
REQ-025 DONE: b_dv[gnt]=1 for exactly one cycle; b_data_in is held stable; update last_gnt=gnt; return to IDLE.
REQ-026 Write completion: in DONE, inv=1, inv_addr=latched addr, and inv_mask=all ones except bit gnt, for one cycle.
REQ-027 Requesters deassert rd/wr in the cycle after b_dv; IDLE never re-grants a channel in the same cycle as its DONE.
REQ-028 Requester address, data and op changes while BUSY are ignored, because the latched copies are used.
REQ-029 h_dv outside BUSY is ignored.
REQ-030 There is no timeout; BUSY waits indefinitely for h_dv.
REQ-031 Fairness: with all channels requesting continuously, each channel is granted once per N_CH transactions.
REQ-032 Minimum transaction length is 3 cycles (IDLE, BUSY with h_dv, DONE).

Reset
REQ-033 rst_n=0 forces, asynchronously: state=IDLE, last_gnt=N_CH-1 so that channel 0 wins first, and all outputs 0 (b_dv, b_data_in, h_rd, h_wr, h_addr, h_data_out, inv, inv_addr, inv_mask).
REQ-034 Reset during BUSY abandons the transaction with no b_dv and no inv; the first request after reset starts a fresh grant.

Structure
REQ-035 Package hmem_pkg holds the FSM state encoding and the default N_CH, LINE and AW constants.
REQ-036 Sub-module rr_arb holds the combinational round-robin picker: N_CH request vector plus last_gnt in, one-hot grant and index out.

Verification
REQ-037 Single read: ch1 rd, addr 0x1000, h_dv after 5 cycles with data 0xA5.. -> h_rd high 5 cycles, then b_dv=0b0010 for one cycle and b_data_in=0xA5...
REQ-038 Write with invalidate: ch2 wr, addr 0x2040 -> h_wr high with h_data_out = ch2 data; on completion, inv=1, inv_addr=0x2040, inv_mask=0b1011.
REQ-039 Round-robin: all 4 channels request together from reset, h_dv after 1 cycle each -> grant order 0,1,2,3, then 0 again.
REQ-040 Conflict: ch0 asserts rd and wr together -> treated as a write; h_wr=1 and h_rd=0.
REQ-041 Reset in BUSY: rst_n low for 1 cycle during ch3 BUSY -> all outputs 0 at once, no b_dv; the next ch3 request is granted normally.
REQ-042 Stray h_dv in IDLE -> no b_dv, no state change.

Source files
------------

// File: rtl/hmem_pkg.sv
// Shared types and default sizes for the hierarchical-memory channel arbiter.
`ifndef HMEM_LINE
`define HMEM_LINE 64
`endif

package hmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } hmem_state_e;

  localparam int unsigned HMEM_N_CH   = 4;
  localparam int unsigned HMEM_LINE_W = `HMEM_LINE;
  localparam int unsigned HMEM_AW     = 64;

endpackage

// File: rtl/hmem_arbn_rr_arb.sv
// Combinational round-robin picker: search starts one past the last grant.
module rr_arb #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned IW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] req,
  input  logic [IW-1:0]   last_gnt,
  output logic [N_CH-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            any
);

  logic [IW-1:0] k;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    k       = '0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      k = IW'((32'(last_gnt) + i) % N_CH);
      if (!any && req[k]) begin
        any      = 1'b1;
        gnt[k]   = 1'b1;
        gnt_idx  = k;
      end
    end
  end

endmodule

// File: rtl/hmem_arbn.sv
// N-channel arbiter in front of a single upstream memory port, with
// invalidate broadcast to the other channels on every completed write.
`ifndef HMEM_LINE
`define HMEM_LINE 64
`endif

module hmem_arbn
  import hmem_pkg::*;
#(
  parameter int unsigned N_CH = HMEM_N_CH,
  parameter int unsigned LINE = `HMEM_LINE,
  parameter int unsigned AW   = HMEM_AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH*AW-1:0]   b_addr,
  input  logic [N_CH-1:0]      b_rd,
  input  logic [N_CH-1:0]      b_wr,
  input  logic [N_CH*LINE-1:0] b_data_out,
  output logic [LINE-1:0]      b_data_in,
  output logic [N_CH-1:0]      b_dv,
  output logic [AW-1:0]        h_addr,
  output logic                 h_rd,
  output logic                 h_wr,
  output logic [LINE-1:0]      h_data_out,
  input  logic [LINE-1:0]      h_data_in,
  input  logic                 h_dv,
  output logic                 inv,
  output logic [AW-1:0]        inv_addr,
  output logic [N_CH-1:0]      inv_mask
);

  localparam int unsigned IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  hmem_state_e     state_q, state_d;
  logic [IW-1:0]   last_gnt_q;
  logic [IW-1:0]   gnt_idx_q;
  logic [N_CH-1:0] gnt_oh_q;
  logic [AW-1:0]   lat_addr;
  logic [LINE-1:0] lat_data;
  logic            lat_wr;
  logic [LINE-1:0] rdata_q;

  logic [N_CH-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [AW-1:0]   sel_addr;
  logic [LINE-1:0] sel_data;
  logic            sel_wr;

  rr_arb #(
    .N_CH (N_CH),
    .IW   (IW)
  ) u_rr_arb (
    .req      (b_rd | b_wr),
    .last_gnt (last_gnt_q),
    .gnt      (pick_oh),
    .gnt_idx  (pick_idx),
    .any      (pick_any)
  );

  // A channel asserting rd and wr together is taken as a write.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_wr   = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (pick_idx == IW'(k)) begin
        sel_addr = b_addr[k*AW +: AW];
        sel_data = b_data_out[k*LINE +: LINE];
        sel_wr   = b_wr[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_any) state_d = ST_BUSY;
      ST_BUSY: if (h_dv)     state_d = ST_DONE;
      ST_DONE:               state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= IW'(N_CH - 1);
      gnt_idx_q  <= '0;
      gnt_oh_q   <= '0;
      lat_addr   <= '0;
      lat_data   <= '0;
      lat_wr     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (pick_any) begin
          gnt_idx_q <= pick_idx;
          gnt_oh_q  <= pick_oh;
          lat_addr  <= sel_addr;
          lat_data  <= sel_data;
          lat_wr    <= sel_wr;
        end
        ST_BUSY: if (h_dv) rdata_q <= h_data_in;
        ST_DONE: last_gnt_q <= gnt_idx_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    h_rd     = 1'b0;
    h_wr     = 1'b0;
    b_dv     = '0;
    inv      = 1'b0;
    inv_addr = '0;
    inv_mask = '0;
    case (state_q)
      ST_BUSY: begin
        h_rd = !lat_wr;
        h_wr = lat_wr;
      end
      ST_DONE: begin
        b_dv = gnt_oh_q;
        if (lat_wr) begin
          inv      = 1'b1;
          inv_addr = lat_addr;
          inv_mask = ~gnt_oh_q;
        end
      end
      default: ;
    endcase
  end

  assign h_addr     = lat_addr;
  assign h_data_out = lat_data;
  assign b_data_in  = rdata_q;

endmodule
